// File: rtl/count_seq_ctrl.sv
// Sequencing controller for a WIDTH-bit counter: start/limit capture, up/down stepping,
// terminal-count flagging, one-shot completion or auto-reload, with pause and abort.
module count_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int RC_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             mode,
    input  logic             pause,
    input  logic             abort,
    output logic             busy,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             done,
    output logic [RC_W-1:0]  reload_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] lim_r;
    logic             dir_r;
    logic             mode_r;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] init;
    logic             at_term;

    // Terminal and reload values derive from the settings captured at start.
    always_comb begin
        term    = dir_r ? lim_r : '0;
        init    = dir_r ? '0 : lim_r;
        at_term = (cnt == term);
    end

    always_comb begin
        busy = (state != IDLE);
        tc   = (state == RUN) && at_term;
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            reload_cnt <= '0;
            lim_r      <= '0;
            dir_r      <= 1'b0;
            mode_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lim_r      <= load_val;
                        dir_r      <= dir;
                        mode_r     <= mode;
                        cnt        <= dir ? '0 : load_val;
                        reload_cnt <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (at_term) begin
                        // Terminal handling outranks pause so tc is seen once per pass.
                        if (!mode_r) begin
                            state <= DONE;
                        end else begin
                            cnt <= init;
                            if (reload_cnt != '1) begin
                                reload_cnt <= reload_cnt + 1'b1;
                            end
                            state <= pause ? HOLD : RUN;
                        end
                    end else if (pause) begin
                        state <= HOLD;
                    end else begin
                        cnt <= dir_r ? cnt + 1'b1 : cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (!pause) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Self-checking bench for count_seq_ctrl: directed scenarios with literal expectations
// plus randomized traffic, all compared every cycle against a step-position model.
module tb_count_seq_ctrl;

    localparam int WIDTH  = 4;
    localparam int RC_W   = 4;
    localparam int RC_MAX = (1 << RC_W) - 1;

    logic             clk = 1'b0;
    logic             rst, start, dir, mode, pause, abort;
    logic [WIDTH-1:0] load_val;
    logic             busy, tc, done;
    logic [WIDTH-1:0] cnt;
    logic [RC_W-1:0]  reload_cnt;

    always #5 clk = ~clk;

    count_seq_ctrl #(.WIDTH(WIDTH), .RC_W(RC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .load_val(load_val), .dir(dir),
        .mode(mode), .pause(pause), .abort(abort), .busy(busy), .cnt(cnt),
        .tc(tc), .done(done), .reload_cnt(reload_cnt)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model: position = steps taken since the pass began; cnt is derived from it.
    int m_busy = 0, m_held = 0, m_fin = 0, m_pos = 0, m_lim = 0;
    int m_dir = 0, m_mode = 0, m_rc = 0, m_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_held = 0; m_fin = 0; m_pos = 0; m_lim = 0;
            m_dir = 0; m_mode = 0; m_rc = 0; m_cnt = 0;
        end else if (m_busy == 0) begin
            if (start) begin
                m_lim = load_val; m_dir = dir; m_mode = mode;
                m_pos = 0; m_busy = 1; m_held = 0; m_fin = 0; m_rc = 0;
            end
        end else if (abort || m_fin != 0) begin
            m_busy = 0; m_fin = 0; m_held = 0;
        end else if (m_held != 0) begin
            if (!pause) m_held = 0;
        end else if (m_pos == m_lim) begin
            if (m_mode == 0) m_fin = 1;
            else begin
                m_pos = 0;
                if (m_rc < RC_MAX) m_rc++;
                m_held = pause ? 1 : 0;
            end
        end else if (pause) begin
            m_held = 1;
        end else begin
            m_pos++;
        end
        if (m_busy != 0) m_cnt = (m_dir != 0) ? m_pos : m_lim - m_pos;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_busy);
            chk("cnt", cnt, m_cnt);
            chk("tc", tc, (m_busy != 0 && m_held == 0 && m_fin == 0 && m_pos == m_lim) ? 1 : 0);
            chk("done", done, m_fin);
            chk("reload_cnt", reload_cnt, m_rc);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic go(input int lv, input logic d, input logic m);
        load_val = lv[WIDTH-1:0]; dir = d; mode = m; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    int exp3[11];
    int c;

    initial begin
        rst = 1'b1; start = 1'b0; dir = 1'b0; mode = 1'b0;
        pause = 1'b0; abort = 1'b0; load_val = '0;
        tick(); tick();
        chk_en = 1'b1;
        rst = 1'b0;
        chk("rst_cnt", cnt, 0); chk("rst_busy", busy, 0);
        chk("rst_tc", tc, 0); chk("rst_done", done, 0); chk("rst_rc", reload_cnt, 0);

        // Down one-shot from 5
        go(5, 1'b0, 1'b0);
        for (int k = 5; k >= 0; k--) begin
            chk("s1_cnt", cnt, k);
            chk("s1_tc", tc, (k == 0) ? 1 : 0);
            if (k > 0) tick();
        end
        tick();
        chk("s1_done", done, 1); chk("s1_done_cnt", cnt, 0); chk("s1_done_busy", busy, 1);
        tick();
        chk("s1_idle_busy", busy, 0); chk("s1_idle_done", done, 0);

        // Up auto-reload to 3
        go(3, 1'b1, 1'b1);
        for (int k = 0; k < 12; k++) begin
            chk("s2_cnt", cnt, k % 4);
            chk("s2_tc", tc, (k % 4 == 3) ? 1 : 0);
            chk("s2_rc", reload_cnt, k / 4);
            chk("s2_done", done, 0);
            tick();
        end
        abort = 1'b1; tick(); abort = 1'b0;
        chk("s2_abort_busy", busy, 0);

        // Pause at cnt=2, down from 6; cnt=2 lingers three extra cycles
        exp3 = '{6, 5, 4, 3, 2, 2, 2, 2, 1, 0, 0};
        go(6, 1'b0, 1'b0);
        c = 0;
        while (busy && c < 30) begin
            if (c < 11) chk("s3_cnt", cnt, exp3[c]);
            pause = (c == 4 || c == 5);
            tick();
            c++;
        end
        pause = 1'b0;
        chk("s3_busy_len", c, 11);

        // Abort at cnt=3, then start+abort together in IDLE
        go(5, 1'b0, 1'b0);
        tick(); tick();
        chk("s4_pre_cnt", cnt, 3);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("s4_busy", busy, 0); chk("s4_cnt", cnt, 3); chk("s4_done", done, 0);
        tick(); tick();
        chk("s4_hold_cnt", cnt, 3); chk("s4_no_done", done, 0);
        abort = 1'b1;
        go(2, 1'b0, 1'b0);
        abort = 1'b0;
        chk("s4_restart_busy", busy, 1); chk("s4_restart_cnt", cnt, 2);
        run_until_idle(20);

        // load_val=0: one-shot, then continuous auto-reload to saturation
        go(0, 1'b0, 1'b0);
        chk("s5_tc", tc, 1); chk("s5_cnt", cnt, 0);
        tick();
        chk("s5_done", done, 1);
        tick();
        chk("s5_idle", busy, 0);
        go(0, 1'b1, 1'b1);
        for (int k = 0; k < 20; k++) tick();
        chk("s5_rc_sat", reload_cnt, 15); chk("s5_tc_cont", tc, 1);
        abort = 1'b1; tick(); abort = 1'b0;

        // Start while busy is ignored; full range both directions
        go(9, 1'b1, 1'b0);
        tick(); tick();
        load_val = 4'd3; dir = 1'b0; mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("s6_ignored_start", cnt, 3);
        run_until_idle(30);
        for (int d = 0; d < 2; d++) begin
            go(15, d[0], 1'b0);
            run_until_idle(40);
        end

        // rst mid-RUN
        go(12, 1'b0, 1'b1);
        tick(); tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("s6_rst_cnt", cnt, 0); chk("s6_rst_busy", busy, 0);
        chk("s6_rst_tc", tc, 0); chk("s6_rst_done", done, 0); chk("s6_rst_rc", reload_cnt, 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            start    = ($urandom_range(0, 7) == 0);
            load_val = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            dir      = $urandom_range(0, 1) == 1;
            mode     = $urandom_range(0, 1) == 1;
            pause    = ($urandom_range(0, 4) == 0);
            abort    = ($urandom_range(0, 39) == 0);
            rst      = ($urandom_range(0, 299) == 0);
            tick();
        end
        start = 1'b0; pause = 1'b0; abort = 1'b0; rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
